// File: rtl/reg_write_arbiter.sv
// Register-file write-port arbiter between pipeline writeback and a multi-cycle unit (MDU).
// A one-entry slot holds an accepted MDU result until it wins the port. WB has priority
// until the slot has lost STARVE_LIMIT times in a row, then the slot is forced through.
// A busy scoreboard tracks MDU destinations in flight so that decode can stall on hazards.
module reg_write_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  output logic        wb_stall,
  input  logic        mdu_issue,
  input  logic [4:0]  mdu_issue_reg,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_reg,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  input  logic        rd_en,
  input  logic [4:0]  rd_reg1,
  input  logic [4:0]  rd_reg2,
  input  logic [4:0]  rd_dst,
  output logic        stall,
  output logic        reg_write,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data
);

  localparam int unsigned CntW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StPend  = 2'd1;
  localparam logic [1:0] StForce = 2'd2;

  logic [1:0]      state_q, state_d;
  logic            pend_valid_q, pend_valid_d;
  logic [4:0]      pend_reg_q, pend_reg_d;
  logic [31:0]     pend_data_q, pend_data_d;
  logic [31:0]     busy_q, busy_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] cnt_inc;
  logic            accept;
  logic            slot_write;

  // No new result is taken while the slot is occupied, including the cycle it drains.
  assign mdu_ready = !reset && !pend_valid_q;
  assign accept    = mdu_valid && mdu_ready;

  // Hazard check uses the registered scoreboard only; busy_q[0] is never set.
  assign stall = !reset && rd_en && (busy_q[rd_reg1] || busy_q[rd_reg2] || busy_q[rd_dst]);

  // Write-port arbitration: combinational, the register file writes on the falling edge.
  always_comb begin
    slot_write = 1'b0;
    wb_stall   = 1'b0;
    reg_write  = 1'b0;
    write_reg  = '0;
    write_data = '0;
    if (!reset) begin
      case (state_q)
        StPend:  slot_write = !wb_valid;
        StForce: slot_write = 1'b1;
        default: slot_write = 1'b0;
      endcase
      if (slot_write) begin
        // A slot aimed at r0 still drains, it just never writes.
        reg_write  = (pend_reg_q != 5'd0);
        write_reg  = pend_reg_q;
        write_data = pend_data_q;
        wb_stall   = wb_valid;
      end else begin
        reg_write  = wb_valid && (wb_reg != 5'd0);
        write_reg  = wb_reg;
        write_data = wb_data;
      end
    end
  end

  // Saturating increment of the starvation counter.
  always_comb begin
    cnt_inc = (cnt_q < CntMax) ? cnt_q + 1'b1 : cnt_q;
  end

  // Slot / FSM / starvation counter next state.
  always_comb begin
    state_d      = state_q;
    pend_valid_d = pend_valid_q;
    pend_reg_d   = pend_reg_q;
    pend_data_d  = pend_data_q;
    cnt_d        = cnt_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d      = StPend;
          pend_valid_d = 1'b1;
          pend_reg_d   = mdu_reg;
          pend_data_d  = mdu_data;
        end
      end
      StPend: begin
        if (wb_valid) begin
          cnt_d = cnt_inc;
          if (cnt_inc >= CntMax) state_d = StForce;
        end else begin
          state_d      = StIdle;
          pend_valid_d = 1'b0;
          cnt_d        = '0;
        end
      end
      default: begin
        // StForce: the slot always writes this cycle.
        state_d      = StIdle;
        pend_valid_d = 1'b0;
        cnt_d        = '0;
      end
    endcase
  end

  // Scoreboard next state: clear on slot write, then set on issue so a same-cycle set wins.
  always_comb begin
    busy_d = busy_q;
    if (slot_write) busy_d[pend_reg_q] = 1'b0;
    if (mdu_issue && (mdu_issue_reg != 5'd0)) busy_d[mdu_issue_reg] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // State registers with synchronous reset; reset discards any pending result.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      pend_valid_q <= 1'b0;
      pend_reg_q   <= '0;
      pend_data_q  <= '0;
      busy_q       <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_reg_q   <= pend_reg_d;
      pend_data_q  <= pend_data_d;
      busy_q       <= busy_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed scenarios followed by random traffic. Each cycle the
// stimulus side pushes the reference model's expected outputs; a negedge monitor pops and compares.
module tb_reg_write_arbiter;

  localparam int LIMIT = 3;

  logic        clock = 1'b1;
  logic        reset;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        wb_stall;
  logic        mdu_issue;
  logic [4:0]  mdu_issue_reg;
  logic        mdu_valid;
  logic [4:0]  mdu_reg;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        rd_en;
  logic [4:0]  rd_reg1, rd_reg2, rd_dst;
  logic        stall;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;

  reg_write_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data), .wb_stall(wb_stall),
    .mdu_issue(mdu_issue), .mdu_issue_reg(mdu_issue_reg),
    .mdu_valid(mdu_valid), .mdu_reg(mdu_reg), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .rd_en(rd_en), .rd_reg1(rd_reg1), .rd_reg2(rd_reg2), .rd_dst(rd_dst), .stall(stall),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        rst;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        wb_stall;
    logic        stall;
    logic        mdu_ready;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: a pending result, how many times in a row it has lost, and busy flags.
  bit          m_busy[32];
  bit          m_pv;
  logic [4:0]  m_preg;
  logic [31:0] m_pdata;
  int          m_losses;
  bit          last_wb_stall;
  bit          last_ready;

  function automatic bit slot_wins();
    return m_pv && (!wb_valid || m_losses >= LIMIT);
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e = '0;
    e.rst = reset;
    if (!reset) begin
      if (slot_wins()) begin
        e.reg_write  = (m_preg != 5'd0);
        e.write_reg  = m_preg;
        e.write_data = m_pdata;
        e.wb_stall   = wb_valid;
      end else begin
        e.reg_write  = wb_valid && (wb_reg != 5'd0);
        e.write_reg  = wb_reg;
        e.write_data = wb_data;
      end
      e.stall = rd_en && ((rd_reg1 != 0 && m_busy[rd_reg1]) ||
                          (rd_reg2 != 0 && m_busy[rd_reg2]) ||
                          (rd_dst  != 0 && m_busy[rd_dst]));
      e.mdu_ready = !m_pv;
    end
    return e;
  endfunction

  task automatic model_step();
    if (reset) begin
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_pv     = 1'b0;
      m_losses = 0;
    end else begin
      if (slot_wins()) begin
        m_busy[m_preg] = 1'b0;
        m_pv     = 1'b0;
        m_losses = 0;
      end else if (m_pv && wb_valid) begin
        m_losses = (m_losses < LIMIT) ? m_losses + 1 : LIMIT;
      end else if (!m_pv && mdu_valid) begin
        m_pv    = 1'b1;
        m_preg  = mdu_reg;
        m_pdata = mdu_data;
      end
      if (mdu_issue && mdu_issue_reg != 5'd0) m_busy[mdu_issue_reg] = 1'b1;
    end
  endtask

  // Inputs for this cycle are already driven: queue the expectation, then advance one clock.
  task automatic cycle();
    exp_t e;
    e = model_out();
    exp_q.push_back(e);
    last_wb_stall = e.wb_stall;
    last_ready    = e.mdu_ready;
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    wb_valid = 0; wb_reg = 0; wb_data = 0;
    mdu_issue = 0; mdu_issue_reg = 0;
    mdu_valid = 0; mdu_reg = 0; mdu_data = 0;
    rd_en = 0; rd_reg1 = 0; rd_reg2 = 0; rd_dst = 0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: outputs are combinational, sampled mid-cycle on the falling edge.
  always @(negedge clock) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("reg_write", {31'd0, reg_write}, {31'd0, e.reg_write});
      if (e.reg_write || e.rst) begin
        check("write_reg", {27'd0, write_reg}, {27'd0, e.write_reg});
        check("write_data", write_data, e.write_data);
      end
      check("wb_stall", {31'd0, wb_stall}, {31'd0, e.wb_stall});
      check("stall", {31'd0, stall}, {31'd0, e.stall});
      check("mdu_ready", {31'd0, mdu_ready}, {31'd0, e.mdu_ready});
    end
  end

  initial begin
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_pv = 0; m_preg = 0; m_pdata = 0; m_losses = 0;
    last_wb_stall = 0; last_ready = 0;
    idle_inputs();
    reset = 1;
    cycle();
    cycle();
    reset = 0;
    cycle();

    // Plain writeback in idle.
    wb_valid = 1; wb_reg = 5; wb_data = 32'h1234;
    cycle();
    idle_inputs();
    cycle();

    // MDU path: issue r8, decode hits it, result accepted, slot drains, stall releases.
    mdu_issue = 1; mdu_issue_reg = 8;
    cycle();
    idle_inputs();
    rd_en = 1; rd_reg1 = 8;
    mdu_valid = 1; mdu_reg = 8; mdu_data = 32'hABCD;
    cycle();
    mdu_valid = 0;
    cycle();
    cycle();
    idle_inputs();
    cycle();

    // Starvation: WB held high wins LIMIT cycles, then the slot is forced through.
    mdu_issue = 1; mdu_issue_reg = 9;
    mdu_valid = 1; mdu_reg = 9; mdu_data = 32'h5555;
    cycle();
    idle_inputs();
    wb_valid = 1; wb_reg = 4; wb_data = 32'h4444;
    repeat (LIMIT + 3) cycle();
    idle_inputs();
    cycle();

    // Register 0: no busy bit, result drains without a write.
    mdu_issue = 1; mdu_issue_reg = 0;
    cycle();
    idle_inputs();
    rd_en = 1; rd_reg1 = 0; rd_reg2 = 0; rd_dst = 0;
    mdu_valid = 1; mdu_reg = 0; mdu_data = 32'h77;
    cycle();
    mdu_valid = 0;
    cycle();
    cycle();
    idle_inputs();

    // Same-register overlap: slot clears r3 while r3 is reissued; set wins.
    mdu_issue = 1; mdu_issue_reg = 3;
    mdu_valid = 1; mdu_reg = 3; mdu_data = 32'h33;
    cycle();
    idle_inputs();
    mdu_issue = 1; mdu_issue_reg = 3;
    cycle();
    idle_inputs();
    rd_en = 1; rd_reg2 = 3;
    mdu_valid = 1; mdu_reg = 3; mdu_data = 32'h3333;
    cycle();
    mdu_valid = 0;
    cycle();
    cycle();
    idle_inputs();

    // Reset while a result is pending and losing to WB.
    mdu_issue = 1; mdu_issue_reg = 12;
    mdu_valid = 1; mdu_reg = 12; mdu_data = 32'hC0DE;
    cycle();
    idle_inputs();
    wb_valid = 1; wb_reg = 6; wb_data = 32'h66;
    cycle();
    reset = 1; rd_en = 1; rd_reg1 = 12;
    cycle();
    reset = 0;
    idle_inputs();
    for (int r = 0; r < 32; r++) begin
      rd_en = 1; rd_reg1 = 5'(r); rd_reg2 = 5'(r); rd_dst = 5'(r);
      cycle();
    end
    idle_inputs();
    cycle();

    // Random traffic; stalled WB and unaccepted MDU results are held like real producers.
    for (int n = 0; n < 4000; n++) begin
      reset = ($urandom_range(0, 249) == 0);
      if (!last_wb_stall) begin
        wb_valid = ($urandom_range(0, 1) == 1);
        wb_reg   = 5'($urandom_range(0, 31));
        wb_data  = $urandom;
      end
      if (!(mdu_valid && !last_ready)) begin
        mdu_valid = ($urandom_range(0, 2) == 0);
        mdu_reg   = 5'($urandom_range(0, 7));
        mdu_data  = $urandom;
      end
      mdu_issue     = ($urandom_range(0, 3) == 0);
      mdu_issue_reg = 5'($urandom_range(0, 7));
      rd_en   = ($urandom_range(0, 1) == 1);
      rd_reg1 = 5'($urandom_range(0, 7));
      rd_reg2 = 5'($urandom_range(0, 7));
      rd_dst  = 5'($urandom_range(0, 7));
      cycle();
    end
    idle_inputs();
    reset = 0;
    cycle();
    @(negedge clock);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3: consecutive cycles a pending MDU result may lose the write port before it is forced through.
REQ-002 SHALL have ports, in order:
- clock  in  1  single clock, all state updates on posedge
- reset  in  1  synchronous, active-high
- wb_valid  in  1  pipeline writeback requests the register-file write port
- wb_reg  in  5  writeback destination
- wb_data  in  32  writeback data
- wb_stall  out  1  writeback lost arbitration; WB stage holds its request unchanged
- mdu_issue  in  1  multi-cycle unit accepted an operation this cycle
- mdu_issue_reg  in  5  destination of that operation
- mdu_valid  in  1  MDU result available
- mdu_reg  in  5  MDU result destination
- mdu_data  in  32  MDU result data
- mdu_ready  out  1  result slot free; result accepted when mdu_valid && mdu_ready
- rd_en  in  1  decode stage has a valid instruction
- rd_reg1, rd_reg2, rd_dst  in  5 each  decode sources and destination
- stall  out  1  decode must hold (scoreboard hit)
- reg_write  out  1  register-file write enable
- write_reg  out  5  register-file write address
- write_data  out  32  register-file write data
REQ-003 SHALL use one clock; reset SHALL be synchronous and active-high.

Function
REQ-004 SHALL hold a one-entry pending slot (pend_valid, pend_reg, pend_data), a 32-bit busy scoreboard, and a starvation counter wide enough for STARVE_LIMIT.
REQ-005 SHALL run a state machine with states IDLE (slot empty), PEND (slot full, WB has priority) and FORCE (slot full, MDU has priority).
REQ-006 Transitions: IDLE->PEND on result accept; PEND->IDLE when the slot writes; PEND->FORCE when the counter reaches STARVE_LIMIT; FORCE->IDLE always after one cycle, because the slot writes.
REQ-007 SHALL drive mdu_ready = !pend_valid, so that no result is accepted in the cycle the slot drains; minimum MDU accept-to-write latency is 1 cycle.
REQ-008 In IDLE: reg_write = wb_valid && wb_reg != 0, write_reg/write_data = wb_reg/wb_data, wb_stall = 0.
REQ-009 In PEND: if wb_valid, WB writes as in REQ-008 and the counter increments; otherwise the slot writes, pend_valid clears and the counter clears.
REQ-010 In FORCE: the slot writes, wb_stall = wb_valid, and the counter clears.
REQ-011 Write-port outputs and wb_stall SHALL be combinational from current state and inputs (the register file writes on negedge); all state SHALL update on posedge.
REQ-012 Writes to register 0 SHALL be suppressed (reg_write = 0), but a pending slot targeting register 0 still drains normally.
REQ-013 Scoreboard set: on posedge, mdu_issue with mdu_issue_reg != 0 SHALL set busy[mdu_issue_reg].
REQ-014 Scoreboard clear: on posedge, a slot write SHALL clear busy[pend_reg]; if a set and a clear hit the same register in one cycle, set wins.
REQ-015 stall = rd_en && (busy[rd_reg1] || busy[rd_reg2] || busy[rd_dst]); busy[0] is constant 0.
REQ-016 Scoreboard lookups SHALL use the registered scoreboard only, with no same-cycle bypass of issue or clear.
REQ-017 Counter saturation: the counter SHALL saturate at STARVE_LIMIT and SHALL NOT increment in IDLE or FORCE.

Reset
REQ-018 While reset = 1, the block SHALL force stall, reg_write, wb_stall and mdu_ready to 0, and write_reg/write_data to 0.
REQ-019 On a reset posedge, the block SHALL clear the scoreboard, pend_valid, pend_reg, pend_data and the counter, and enter IDLE.
REQ-020 A result accepted or pending when reset asserts SHALL be discarded, including mid-arbitration.
REQ-021 The first cycle after reset deasserts SHALL behave as IDLE with mdu_ready = 1.

Verification
REQ-022 Plain writeback: wb_valid=1, wb_reg=5, wb_data=0x1234 in IDLE -> reg_write=1, write_reg=5, write_data=0x1234 that cycle; wb_stall=0.
REQ-023 MDU path: issue reg 8, then rd_reg1=8 with rd_en=1 -> stall=1; result mdu_reg=8, data 0xABCD accepted, WB idle the next cycle -> that cycle writes 8/0xABCD, and stall=0 from the following cycle.
REQ-024 Starvation: slot full and wb_valid held high -> WB wins 3 cycles, then a FORCE cycle in which the slot writes and wb_stall=1, then WB resumes with wb_stall=0.
REQ-025 Register 0: mdu_issue_reg=0 -> busy is unchanged and stall=0; the result to reg 0 is accepted, drains with reg_write=0, and mdu_ready returns to 1.
REQ-026 Same-register overlap: a slot write to reg 3 in the same cycle as mdu_issue_reg=3 -> busy[3] remains 1 and rd_reg2=3 still stalls.
REQ-027 Reset mid-PEND: reset=1 for one cycle -> all outputs 0 during reset; afterwards mdu_ready=1, stall=0 for every register, and no stale write occurs.
